// File: rtl/logdrop_window_accum_if.sv
// Sample-side and result-side handshake bundle for logdrop_window_accum.
// Latency: none; wires only.
// Backpressure: o_ready throttles the sample source, i_sumReady throttles the result.
interface logdrop_window_accum_if #(
    parameter int DATA_W = 8,
    parameter int WINLEN = 64
);
    localparam int T_W   = $clog2(WINLEN);
    localparam int SUM_W = DATA_W + T_W;

    // sample side: source offers i_valid, stage answers o_ready; o_t selects
    // the window position and i_y is the dropped sample for that position
    logic              i_valid;
    logic              o_ready;
    logic [T_W-1:0]    o_t;
    logic [DATA_W-1:0] i_y;

    // result side: one sum per completed window
    logic [SUM_W-1:0]  o_sum;
    logic              o_sumValid;
    logic              i_sumReady;

    // the accumulator stage
    modport slave (
        input  i_valid,
        input  i_y,
        input  i_sumReady,
        output o_ready,
        output o_t,
        output o_sum,
        output o_sumValid
    );

    // the surrounding source / sink / logdropWindow
    modport master (
        output i_valid,
        output i_y,
        output i_sumReady,
        input  o_ready,
        input  o_t,
        input  o_sum,
        input  o_sumValid
    );
endinterface

// File: rtl/logdrop_window_accum.sv
// Sums WINLEN dropped samples per window and emits one sum per window.
// Latency: sum valid one cycle after the window's last sample is accepted.
// Backpressure: input stalls only on a window's last sample while the previous sum is unconsumed.
module logdrop_window_accum #(
    parameter int DATA_W = 8,
    parameter int WINLEN = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    logdrop_window_accum_if.slave bus
);
    // WINLEN is a power of two >= 2, so T_W bits index exactly one window and
    // SUM_W bits hold WINLEN * (2^DATA_W - 1) without overflow.
    localparam int T_W   = $clog2(WINLEN);
    localparam int SUM_W = DATA_W + T_W;
    localparam logic [T_W-1:0] T_LAST = T_W'(WINLEN - 1);

    logic [T_W-1:0]   t;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] sum_q;
    logic             sum_vld;

    logic             last;
    logic             stall;
    logic             ready;
    logic             accept;
    logic             complete;
    logic             drain;
    logic [SUM_W-1:0] y_ext;
    logic [SUM_W-1:0] acc_base;
    logic [SUM_W-1:0] acc_next;

    // handshake decode and accumulator next value; i_y arrives combinationally
    // from logdropWindow driven by o_t, so no register sits on this path
    always_comb begin
        last     = (t == T_LAST);
        stall    = last && sum_vld && !bus.i_sumReady;
        ready    = !i_clr && !stall;
        accept   = bus.i_valid && ready;
        complete = accept && last;
        drain    = sum_vld && bus.i_sumReady;
        y_ext    = {{T_W{1'b0}}, bus.i_y};
        // position 0 always starts a fresh window, whatever acc holds
        acc_base = (t == '0) ? '0 : acc;
        acc_next = acc_base + y_ext;
    end

    // window position: advances once per accepted sample, wraps on completion or clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            t <= '0;
        end else if (i_clr) begin
            t <= '0;
        end else if (accept) begin
            t <= last ? '0 : t + T_W'(1);
        end
    end

    // running partial sum of the current window
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc <= '0;
        end else if (i_clr) begin
            acc <= '0;
        end else if (accept) begin
            acc <= last ? '0 : acc_next;
        end
    end

    // result register: loads only on completion, so it cannot move while a
    // result waits (the last sample is stalled in that case)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q <= '0;
        end else if (complete) begin
            // t is nonzero here (WINLEN >= 2), so acc_next is acc + i_y
            sum_q <= acc_next;
        end
    end

    // result valid: set on completion (wins over a same-cycle drain), cleared on drain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_vld <= 1'b0;
        end else if (complete) begin
            sum_vld <= 1'b1;
        end else if (drain) begin
            sum_vld <= 1'b0;
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_t        = t;
    assign bus.o_sum      = sum_q;
    assign bus.o_sumValid = sum_vld;
endmodule
